// File: rtl/jnwtr_ckdiv_pkg.sv
// Shared definitions for the programmable clock divider.
//   ckdiv_state_e : divider FSM states (IDLE, RUN, STOP)
//   DIV_MIN       : smallest ratio the divider will run at
//   clamp_div()   : lifts requested ratios below DIV_MIN up to DIV_MIN
package jnwtr_ckdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } ckdiv_state_e;

  localparam int unsigned DIV_MIN = 2;

  // Ratios 0 and 1 cannot produce a high and a low phase, so they run as 2.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
  endfunction

endpackage

// File: rtl/jnwtr_ckdivn.sv
// Programmable integer clock divider with a glitch-free stop.
// Divides CK by the active ratio N into CKO. The high phase is H = (N+1)>>1
// cycles and the low phase is N-H cycles. A stop request never truncates a
// period; the divider parks at the next period boundary.
//
// Ports:
//   CK        in   clock, all logic on posedge
//   RN        in   synchronous active-low reset
//   EN        in   run request (level)
//   DIV       in   requested ratio, captured when LOAD=1
//   LOAD      in   one-cycle strobe capturing DIV into the pending register
//   CKO       out  divided clock (registered)
//   CKO_PLS   out  one-cycle pulse in the first CK cycle of each CKO period
//   ACK       out  one-cycle pulse when the pending ratio becomes active
//   DIV_ACT   out  currently active ratio
//   RUNNING   out  high in RUN and STOP
//   DBG_STATE out  FSM state, for observation only
//
// Ratio handshake: LOAD is a fire-and-forget request (no back-pressure). A
// captured ratio stays pending until the first period boundary after the
// capture edge (or the next edge while idle), where it becomes active and
// ACK pulses once. A LOAD while a ratio is pending replaces that ratio and
// still yields a single ACK.
module jnwtr_ckdivn
  import jnwtr_ckdiv_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 2
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV,
  input  logic             LOAD,
  output logic             CKO,
  output logic             CKO_PLS,
  output logic             ACK,
  output logic [DIV_W-1:0] DIV_ACT,
  output logic             RUNNING,
  output logic [1:0]       DBG_STATE
);

  localparam logic [DIV_W-1:0] DIV_RST_W = DIV_W'(DIV_RST);
  localparam logic [DIV_W-1:0] ONE_W     = DIV_W'(1);
  localparam logic [DIV_W:0]   ONE_W1    = (DIV_W+1)'(1);

  ckdiv_state_e     state_q;
  logic [DIV_W-1:0] cnt_q;
  logic             cko_q;
  logic             pls_q;
  logic             ack_q;
  logic             run_q;
  logic [DIV_W-1:0] div_act_q;
  logic [DIV_W-1:0] pend_q;
  logic             pend_vld_q;

  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W:0]   high_len;
  logic             boundary;
  logic             apply;
  logic [DIV_W-1:0] div_clamped;

  // One extra bit so (N+1) does not wrap for the largest ratio.
  assign high_len    = ({1'b0, div_act_q} + ONE_W1) >> 1;
  assign cnt_d       = (cnt_q == div_act_q - ONE_W) ? '0 : cnt_q + ONE_W;
  assign boundary    = (state_q != IDLE) && (cnt_d == '0);
  // pend_vld_q only becomes visible the edge after a LOAD, so a LOAD that
  // coincides with a boundary is naturally held for the following one.
  assign apply       = pend_vld_q && ((state_q == IDLE) || boundary);
  assign div_clamped = DIV_W'(clamp_div(32'(DIV)));

  always_ff @(posedge CK) begin
    if (!RN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cko_q      <= 1'b0;
      pls_q      <= 1'b0;
      ack_q      <= 1'b0;
      run_q      <= 1'b0;
      div_act_q  <= DIV_RST_W;
      pend_q     <= DIV_RST_W;
      pend_vld_q <= 1'b0;
    end else begin
      ack_q <= apply;
      if (apply) begin
        div_act_q <= pend_q;
      end
      // A fresh capture wins over clearing: it belongs to a later boundary.
      if (LOAD) begin
        pend_q     <= div_clamped;
        pend_vld_q <= 1'b1;
      end else if (apply) begin
        pend_vld_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (EN) begin
            state_q <= RUN;
            cnt_q   <= '0;
            cko_q   <= 1'b1;
            pls_q   <= 1'b1;
            run_q   <= 1'b1;
          end else begin
            cko_q <= 1'b0;
            pls_q <= 1'b0;
            run_q <= 1'b0;
          end
        end
        RUN, STOP: begin
          if ((state_q == STOP) && boundary && !EN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cko_q   <= 1'b0;
            pls_q   <= 1'b0;
            run_q   <= 1'b0;
          end else begin
            // STOP keeps counting exactly like RUN, so re-raising EN
            // resumes with no phase disturbance.
            state_q <= EN ? RUN : STOP;
            cnt_q   <= cnt_d;
            cko_q   <= ({1'b0, cnt_d} < high_len);
            pls_q   <= boundary;
            run_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          cko_q   <= 1'b0;
          pls_q   <= 1'b0;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  assign CKO       = cko_q;
  assign CKO_PLS   = pls_q;
  assign ACK       = ack_q;
  assign DIV_ACT   = div_act_q;
  assign RUNNING   = run_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_jnwtr_ckdivn.sv
module tb_jnwtr_ckdivn;

  // ---------------- clock / reset ----------------
  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic       EN = 1'b0;
  logic [7:0] DIV = 8'd0;
  logic       LOAD = 1'b0;
  logic       CKO, CKO_PLS, ACK, RUNNING;
  logic [7:0] DIV_ACT;
  logic [1:0] DBG_STATE;

  always #5 CK = ~CK;

  jnwtr_ckdivn #(.DIV_W(8), .DIV_RST(2)) dut (
    .CK(CK), .RN(RN), .EN(EN), .DIV(DIV), .LOAD(LOAD),
    .CKO(CKO), .CKO_PLS(CKO_PLS), .ACK(ACK), .DIV_ACT(DIV_ACT),
    .RUNNING(RUNNING), .DBG_STATE(DBG_STATE)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each period is generated as a whole waveform (H ones, N-H zeros) and
  // consumed one cycle at a time; an empty queue means a period boundary.
  bit wq[$];
  int m_n = 2, m_pend = 2;
  bit m_pv = 0, m_run = 0, m_stopping = 0;
  bit e_cko = 0, e_pls = 0, e_ack = 0;

  function automatic void start_period();
    int h;
    h = (m_n + 1) / 2;
    wq.delete();
    for (int i = 0; i < m_n; i++) wq.push_back(i < h);
  endfunction

  always @(posedge CK) begin
    if (!RN) begin
      m_n = 2; m_pv = 0; m_run = 0; m_stopping = 0;
      wq.delete();
      e_cko = 0; e_pls = 0; e_ack = 0;
    end else begin
      bit apply;
      apply = m_pv && (!m_run || wq.size() == 0);
      e_ack = apply;
      if (apply) begin
        m_n = m_pend;
        m_pv = 0;
      end
      if (!m_run) begin
        if (EN) begin
          m_run = 1;
          start_period();
          e_cko = wq.pop_front();
          e_pls = 1;
        end else begin
          e_cko = 0; e_pls = 0;
        end
      end else if (wq.size() == 0) begin
        if (m_stopping && !EN) begin
          m_run = 0; e_cko = 0; e_pls = 0;
        end else begin
          start_period();
          e_cko = wq.pop_front();
          e_pls = 1;
        end
      end else begin
        e_cko = wq.pop_front();
        e_pls = 0;
      end
      m_stopping = m_run && !EN;
      if (LOAD) begin
        m_pend = (DIV < 2) ? 2 : int'(DIV);
        m_pv = 1;
      end
    end
    #1;
    chk("m_cko",     CKO,     e_cko);
    chk("m_pls",     CKO_PLS, e_pls);
    chk("m_ack",     ACK,     e_ack);
    chk("m_div_act", DIV_ACT, m_n);
    chk("m_running", RUNNING, m_run);
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge CK);
  endtask

  // Samples CKO on the next len edges and compares with bits, MSB first.
  task automatic expect_cko(input string nm, input logic [15:0] bits, input int len);
    for (int i = 0; i < len; i++) begin
      @(posedge CK); #2;
      chk($sformatf("%s[%0d]", nm, i), CKO, bits[len-1-i]);
    end
  endtask

  task automatic wait_pls(input string nm, input int max_cyc);
    bit seen;
    seen = 0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(posedge CK); #2;
      if (CKO_PLS) seen = 1;
    end
    if (!seen) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic load(input logic [7:0] d);
    @(negedge CK); LOAD = 1'b1; DIV = d;
    @(negedge CK); LOAD = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acks, highs, pulses;
    cyc(3);
    chk("rst_cko", CKO, 0);
    chk("rst_div_act", DIV_ACT, 2);
    chk("rst_running", RUNNING, 0);
    RN = 1'b1;
    cyc(1);

    // 1: default ratio 2
    EN = 1'b1;
    expect_cko("t1", 16'b1010, 4);
    chk("t1_running", RUNNING, 1);
    @(negedge CK); EN = 1'b0;
    cyc(6);

    // 2: load 5 while idle
    load(8'd5);
    @(posedge CK); #2;
    chk("t2_ack", ACK, 1);
    chk("t2_div_act", DIV_ACT, 5);
    @(negedge CK); EN = 1'b1;
    expect_cko("t2", 16'b1110011100, 10);

    // 3: ratio change mid-period, then overwrite with a coincident load
    @(negedge CK);
    @(negedge CK); LOAD = 1'b1; DIV = 8'd4;
    @(negedge CK); LOAD = 1'b0;
    expect_cko("t3a", 16'b10011001100, 11);
    @(negedge CK); LOAD = 1'b1; DIV = 8'd7;
    @(negedge CK); DIV = 8'd6;
    @(negedge CK); LOAD = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CK); #2;
      acks += int'(ACK);
    end
    chk("t3_single_ack", acks, 1);
    chk("t3_div_act", DIV_ACT, 6);

    // 4: stop mid-high phase with N=7, then stop/resume
    load(8'd7);
    wait_pls("t4_pls", 20);
    @(negedge CK);
    @(negedge CK);
    @(negedge CK); EN = 1'b0;
    expect_cko("t4_stop", 16'b1000000, 7);
    chk("t4_idle_running", RUNNING, 0);
    @(negedge CK); EN = 1'b1;
    wait_pls("t4_restart", 20);
    @(negedge CK); EN = 1'b0;
    @(negedge CK); EN = 1'b1;
    expect_cko("t4_resume", 16'b1100011110, 10);

    // 5: clamping and the largest ratio
    @(negedge CK); EN = 1'b0;
    cyc(12);
    load(8'd0);
    @(posedge CK); #2;
    chk("t5_clamp0", DIV_ACT, 2);
    load(8'd1);
    @(posedge CK); #2;
    chk("t5_clamp1", DIV_ACT, 2);
    chk("t5_clamp1_ack", ACK, 1);
    load(8'd255);
    @(posedge CK); #2;
    chk("t5_div255", DIV_ACT, 255);
    @(negedge CK); EN = 1'b1;
    highs = 0; pulses = 0;
    for (int i = 0; i < 255; i++) begin
      @(posedge CK); #2;
      highs  += int'(CKO);
      pulses += int'(CKO_PLS);
    end
    chk("t5_high_cycles", highs, 128);
    chk("t5_pulses", pulses, 1);
    @(posedge CK); #2;
    chk("t5_wrap_pls", CKO_PLS, 1);

    // 6: reset mid high phase with a ratio pending
    @(negedge CK); LOAD = 1'b1; DIV = 8'd9;
    @(negedge CK); LOAD = 1'b0; RN = 1'b0;
    @(posedge CK); #2;
    chk("t6_cko", CKO, 0);
    chk("t6_pls", CKO_PLS, 0);
    chk("t6_ack", ACK, 0);
    chk("t6_running", RUNNING, 0);
    chk("t6_div_act", DIV_ACT, 2);
    @(negedge CK); RN = 1'b1; EN = 1'b0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CK); #2;
      acks += int'(ACK);
    end
    chk("t6_no_ack", acks, 0);
    chk("t6_div_kept", DIV_ACT, 2);

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
